// File: rtl/mdu_iter_if.sv
// mdu_iter request/result bundle.
// Controller drives requests; the MDU returns busy/done and HI/LO.
interface mdu_iter_if;
  logic        start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, MDUOp, A, B,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, MDUOp, A, B,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers.
// Optional MADD/MADDU accumulate path enabled by macro MDU_MADD_EN.
module mdu_iter #(
  parameter int unsigned MUL_CYCLES = 5
) (
  input logic        clk,
  input logic        reset,
  mdu_iter_if.slave  bus
);

  localparam int unsigned DIV_CYCLES = 33;
  localparam logic [4:0] MUL_LD = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LD = 5'(DIV_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic [63:0] prod;
  logic        madd;
  logic [31:0] quo;
  logic [31:0] dsr;
  logic [31:0] rem;
  logic        neg_q;
  logic        neg_r;
  logic        dz;
  logic        done_q;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        is_mul;
  logic        is_div;
  logic        is_mt;
  logic        is_madd;
  logic        signed_op;
  logic        accept;
  logic        mul_commit;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Opcode decode; 11x only means something with the accumulate path.
  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mt   = 1'b0;
    is_madd = 1'b0;
    unique case (1'b1)
      (bus.MDUOp[2:1] == 2'b00): is_mul = 1'b1;
      (bus.MDUOp[2:1] == 2'b01): is_div = 1'b1;
      (bus.MDUOp[2:1] == 2'b10): is_mt  = 1'b1;
      default: begin
`ifdef MDU_MADD_EN
        is_mul  = 1'b1;
        is_madd = 1'b1;
`else
        is_mul  = 1'b0;
        is_madd = 1'b0;
`endif
      end
    endcase
  end

  assign signed_op  = ~bus.MDUOp[0];
  assign accept     = bus.start && (state == IDLE);
  assign mul_commit = (state == MUL) && (cnt == 5'd0);

  assign mul_a = {{32{signed_op & bus.A[31]}}, bus.A};
  assign mul_b = {{32{signed_op & bus.B[31]}}, bus.B};
  assign abs_a = (signed_op & bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
  assign abs_b = (signed_op & bus.B[31]) ? (~bus.B + 32'd1) : bus.B;

  // One restoring step: quotient register doubles as dividend shifter.
  assign rem_sh = {rem, quo[31]};
  assign ge     = rem_sh >= {1'b0, dsr};
  assign rem_nx = ge ? (rem_sh[31:0] - dsr) : rem_sh[31:0];
  assign quo_nx = {quo[30:0], ge};

  assign q_fix = neg_q ? (~quo + 32'd1) : quo;
  assign r_fix = neg_r ? (~rem + 32'd1) : rem;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept && is_mul)      state_nxt = MUL;
        else if (accept && is_div) state_nxt = DIV;
      end
      MUL: if (cnt == 5'd0) state_nxt = IDLE;
      DIV: if (cnt == 5'd0) state_nxt = FIX;
      FIX: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: busy follows the registered state.
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = done_q;
    bus.HI   = hi;
    bus.LO   = lo;
  end

  // Datapath, counter, HI/LO and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      prod   <= '0;
      madd   <= 1'b0;
      quo    <= '0;
      dsr    <= '0;
      rem    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      done_q <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept && is_mt) begin
        if (bus.MDUOp[0]) lo <= bus.A;
        else              hi <= bus.A;
      end
      if (accept && is_mul) begin
        prod <= mul_a * mul_b;
        madd <= is_madd;
        cnt  <= MUL_LD;
      end else if (accept && is_div) begin
        quo   <= abs_a;
        dsr   <= abs_b;
        rem   <= '0;
        neg_q <= signed_op & (bus.A[31] ^ bus.B[31]);
        neg_r <= signed_op & bus.A[31];
        dz    <= (bus.B == 32'd0);
        cnt   <= DIV_LD;
      end else if (cnt != 5'd0) begin
        cnt <= cnt - 5'd1;
      end
      if (state == DIV) begin
        rem <= rem_nx;
        quo <= quo_nx;
      end
      if (mul_commit) begin
        {hi, lo} <= madd ? ({hi, lo} + prod) : prod;
        done_q   <= 1'b1;
      end
      if (state == FIX) begin
        if (!dz) begin
          lo <= q_fix;
          hi <= r_fix;
        end
        done_q <= 1'b1;
      end
    end
  end

endmodule
